// File: rtl/fpu_result_queue.sv
// Result buffer behind the non-stallable FPU wrapper: a first-word fall-through
// FIFO for {result, flags, tag} plus a credit counter that throttles issue.

package fpu_defs;
  localparam int unsigned C_OP   = 32;
  localparam int unsigned C_FLAG = 5;
  localparam int unsigned C_TAG  = 8;
endpackage

module fpu_result_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned C_OP   = fpu_defs::C_OP,
  parameter int unsigned C_FLAG = fpu_defs::C_FLAG,
  parameter int unsigned C_TAG  = fpu_defs::C_TAG,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              IssueReq_SI,
  output logic              IssueGnt_SO,
  input  logic              ResValid_SI,
  input  logic [C_OP-1:0]   ResData_DI,
  input  logic [C_FLAG-1:0] ResFlags_DI,
  input  logic [C_TAG-1:0]  ResTag_DI,
  output logic              OutValid_SO,
  input  logic              OutReady_SI,
  output logic [C_OP-1:0]   OutData_DO,
  output logic [C_FLAG-1:0] OutFlags_DO,
  output logic [C_TAG-1:0]  OutTag_DO,
  output logic [CNT_W-1:0]  Count_SO,
  output logic [CNT_W-1:0]  Credits_SO,
  output logic              Overflow_SO
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [C_OP-1:0]   data;
    logic [C_FLAG-1:0] flags;
    logic [C_TAG-1:0]  tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   credits_q, credits_d;
  logic               overflow_q, overflow_d;

  logic is_empty, is_full, pop, push, drop, issue_acc;

  // Handshakes: an output entry transfers on a cycle where OutValid_SO && OutReady_SI;
  // an issue is accepted where IssueReq_SI && IssueGnt_SO; ResValid_SI has no ready
  // and is taken whenever there is room (or a pop frees a slot in the same cycle).
  always_comb begin
    is_empty  = (count_q == '0);
    is_full   = (count_q == CNT_W'(DEPTH));
    pop       = !is_empty && OutReady_SI;
    push      = ResValid_SI && (!is_full || pop);
    drop      = ResValid_SI && is_full && !pop;
    issue_acc = IssueReq_SI && (credits_q != '0);
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credits_d  = credits_q;
    overflow_d = overflow_q | drop;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: ResData_DI, flags: ResFlags_DI, tag: ResTag_DI};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A pop returns a credit; saturate so a stray pop cannot push credits past DEPTH.
    if (issue_acc && !pop) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (pop && !issue_acc && (credits_q != CNT_W'(DEPTH))) begin
      credits_d = credits_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credits_q  <= CNT_W'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign IssueGnt_SO = (credits_q != '0);
  assign OutValid_SO = !is_empty;
  assign OutData_DO  = mem_q[rd_ptr_q].data;
  assign OutFlags_DO = mem_q[rd_ptr_q].flags;
  assign OutTag_DO   = mem_q[rd_ptr_q].tag;
  assign Count_SO    = count_q;
  assign Credits_SO  = credits_q;
  assign Overflow_SO = overflow_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Bench for fpu_result_queue: directed scenarios plus random traffic, checked against
// a queue-based model and a 1-cycle FPU latency model.

module tb_fpu_result_queue;

  localparam int DEPTH = 4;
  localparam int OPW   = 32;
  localparam int FW    = 5;
  localparam int TW    = 8;
  localparam int CW    = 3;
  localparam int EW    = OPW + FW + TW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          IssueReq = 1'b0;
  logic          IssueGnt;
  logic          ResValid = 1'b0;
  logic [OPW-1:0] ResData = '0;
  logic [FW-1:0]  ResFlags = '0;
  logic [TW-1:0]  ResTag = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [OPW-1:0] OutData;
  logic [FW-1:0]  OutFlags;
  logic [TW-1:0]  OutTag;
  logic [CW-1:0]  Count;
  logic [CW-1:0]  Credits;
  logic          Overflow;

  logic [OPW-1:0] iss_data = '0;
  logic [FW-1:0]  iss_flags = '0;
  logic [TW-1:0]  iss_tag = '0;

  logic [EW-1:0] exp_q[$];
  int credits_m  = DEPTH;
  int inflight_m = 0;
  bit ovf_m      = 1'b0;
  bit compliant  = 1'b1;
  int errors     = 0;
  int checks     = 0;

  fpu_result_queue #(.DEPTH(DEPTH)) dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .IssueReq_SI (IssueReq),
    .IssueGnt_SO (IssueGnt),
    .ResValid_SI (ResValid),
    .ResData_DI  (ResData),
    .ResFlags_DI (ResFlags),
    .ResTag_DI   (ResTag),
    .OutValid_SO (OutValid),
    .OutReady_SI (OutReady),
    .OutData_DO  (OutData),
    .OutFlags_DO (OutFlags),
    .OutTag_DO   (OutTag),
    .Count_SO    (Count),
    .Credits_SO  (Credits),
    .Overflow_SO (Overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model from the inputs seen at the edge, then
  // drive the FPU result for any op accepted at that edge.
  task automatic tick();
    logic          acc;
    logic          pop;
    logic [EW-1:0] pl;
    logic [EW-1:0] head;
    @(posedge clk);
    acc = 1'b0;
    pl  = '0;
    if (rst_n) begin
      acc = IssueReq && (credits_m > 0);
      pop = (exp_q.size() > 0) && OutReady;
      if (pop) head = exp_q.pop_front();
      if (ResValid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({ResData, ResFlags, ResTag});
        else ovf_m = 1'b1;
      end
      if (acc && !pop) credits_m--;
      else if (pop && !acc && credits_m < DEPTH) credits_m++;
      inflight_m = acc ? 1 : 0;
      pl = {iss_data, iss_flags, iss_tag};
    end else begin
      inflight_m = 0;
    end
    #1;
    ResValid = acc;
    {ResData, ResFlags, ResTag} = acc ? pl : '0;
  endtask

  task automatic fill(input logic [TW-1:0] first_tag);
    for (int i = 0; i < DEPTH; i++) begin
      iss_data  = $urandom;
      iss_flags = FW'($urandom_range(0, 31));
      iss_tag   = first_tag + TW'(i);
      IssueReq  = 1'b1;
      tick();
    end
    IssueReq = 1'b0;
    tick();
  endtask

  // Scoreboard: every cycle out of reset the DUT state must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (OutValid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL mon_valid got=%b exp=%b", OutValid, exp_q.size() != 0);
      end
      checks++;
      if (Count !== CW'(exp_q.size())) begin
        errors++; $display("FAIL mon_count got=%0d exp=%0d", Count, exp_q.size());
      end
      checks++;
      if (Credits !== CW'(credits_m)) begin
        errors++; $display("FAIL mon_credits got=%0d exp=%0d", Credits, credits_m);
      end
      checks++;
      if (IssueGnt !== (credits_m != 0)) begin
        errors++; $display("FAIL mon_gnt got=%b exp=%b", IssueGnt, credits_m != 0);
      end
      checks++;
      if (Overflow !== ovf_m) begin
        errors++; $display("FAIL mon_overflow got=%b exp=%b", Overflow, ovf_m);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if ({OutData, OutFlags, OutTag} !== exp_q[0]) begin
          errors++;
          $display("FAIL mon_head got=%h/%h/%h exp=%h", OutData, OutFlags, OutTag, exp_q[0]);
        end
      end
      if (compliant) begin
        checks++;
        if (int'(Credits) + int'(Count) + inflight_m != DEPTH) begin
          errors++;
          $display("FAIL mon_invariant credits=%0d count=%0d inflight=%0d exp_sum=%0d",
                   Credits, Count, inflight_m, DEPTH);
        end
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if (OutValid !== 1'b0 || Count !== 3'd0 || Credits !== 3'd4) begin
      errors++; $display("FAIL reset_async got v=%b c=%0d cr=%0d exp v=0 c=0 cr=4", OutValid, Count, Credits);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (Credits !== 3'd4) begin errors++; $display("FAIL reset_credits got=%0d exp=4", Credits); end
    checks++;
    if (IssueGnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got=%b exp=1", IssueGnt); end
    checks++;
    if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", OutValid); end
    checks++;
    if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Count); end
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", Overflow); end
    checks++;
    if (OutData !== 32'd0 || OutFlags !== 5'd0 || OutTag !== 8'd0) begin
      errors++; $display("FAIL reset_head got=%h/%h/%h exp=0/0/0", OutData, OutFlags, OutTag);
    end
  endtask

  task automatic test_back_to_back();
    logic [OPW-1:0] exp_data [DEPTH];
    exp_data[0] = 32'h3F80_0000;
    exp_data[1] = 32'h4000_0000;
    exp_data[2] = 32'h4040_0000;
    exp_data[3] = 32'h4080_0000;
    OutReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      iss_data  = exp_data[i];
      iss_flags = FW'($urandom_range(0, 31));
      iss_tag   = TW'(i + 1);
      IssueReq  = 1'b1;
      tick();
    end
    IssueReq = 1'b0;
    checks++;
    if (IssueGnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt_low got=%b exp=0", IssueGnt); end
    tick();
    checks++;
    if (Count !== 3'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", Count); end
    OutReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (OutValid !== 1'b1 || OutTag !== TW'(i + 1) || OutData !== exp_data[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d] got v=%b tag=%0d data=%h exp v=1 tag=%0d data=%h",
                 i, OutValid, OutTag, OutData, i + 1, exp_data[i]);
      end
      tick();
    end
    checks++;
    if (Credits !== 3'd4 || OutValid !== 1'b0) begin
      errors++; $display("FAIL b2b_drained got cr=%0d v=%b exp cr=4 v=0", Credits, OutValid);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_single_push();
    iss_data  = 32'h4049_0FDB;
    iss_flags = 5'h04;
    iss_tag   = 8'd7;
    IssueReq  = 1'b1;
    tick();
    IssueReq = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", OutValid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (OutValid !== 1'b1 || OutData !== 32'h4049_0FDB || OutFlags !== 5'h04 || OutTag !== 8'd7) begin
        errors++;
        $display("FAIL single_head[%0d] got v=%b d=%h f=%h t=%0d exp v=1 d=40490fdb f=04 t=7",
                 k, OutValid, OutData, OutFlags, OutTag);
      end
      if (k < 3) tick();
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin errors++; $display("FAIL single_popped got=%b exp=0", OutValid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      IssueReq  = $urandom_range(0, 1) != 0;
      OutReady  = $urandom_range(0, 3) == 0;
      if (c >= 200) OutReady = $urandom_range(0, 3) != 0;
      iss_data  = $urandom;
      iss_flags = FW'($urandom_range(0, 31));
      iss_tag   = TW'($urandom_range(0, 255));
      tick();
    end
    IssueReq = 1'b0;
    OutReady = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() > 0 || inflight_m > 0); c++) tick();
    checks++;
    if (Count !== 3'd0 || Credits !== 3'd4) begin
      errors++; $display("FAIL random_drain got c=%0d cr=%0d exp c=0 cr=4", Count, Credits);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [TW-1:0] exp_tag [DEPTH];
    exp_tag[0] = 8'h12; exp_tag[1] = 8'h13; exp_tag[2] = 8'h14; exp_tag[3] = 8'h09;
    OutReady = 1'b0;
    fill(8'h11);
    checks++;
    if (Count !== 3'd4) begin errors++; $display("FAIL fpp_full got=%0d exp=4", Count); end
    compliant = 1'b0;
    ResValid  = 1'b1;
    ResData   = $urandom;
    ResFlags  = 5'h01;
    ResTag    = 8'h09;
    OutReady  = 1'b1;
    tick();
    checks++;
    if (Count !== 3'd4 || Overflow !== 1'b0) begin
      errors++; $display("FAIL fpp_same_cycle got c=%0d ovf=%b exp c=4 ovf=0", Count, Overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (OutValid !== 1'b1 || OutTag !== exp_tag[i]) begin
        errors++; $display("FAIL fpp_order[%0d] got v=%b tag=%h exp v=1 tag=%h", i, OutValid, OutTag, exp_tag[i]);
      end
      tick();
    end
    checks++;
    if (OutValid !== 1'b0 || Overflow !== 1'b0) begin
      errors++; $display("FAIL fpp_end got v=%b ovf=%b exp v=0 ovf=0", OutValid, Overflow);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_overflow();
    OutReady = 1'b0;
    fill(8'h21);
    ResValid = 1'b1;
    ResData  = $urandom;
    ResFlags = 5'h1F;
    ResTag   = 8'hEE;
    tick();
    checks++;
    if (Overflow !== 1'b1 || Count !== 3'd4) begin
      errors++; $display("FAIL ovf_set got ovf=%b c=%0d exp ovf=1 c=4", Overflow, Count);
    end
    tick();
    tick();
    checks++;
    if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", Overflow); end
    OutReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (OutTag === 8'hEE || OutTag !== 8'h21 + TW'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d] got tag=%h exp tag=%h", i, OutTag, 8'h21 + TW'(i));
      end
      tick();
    end
    checks++;
    if (OutValid !== 1'b0 || Overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_end got v=%b ovf=%b exp v=0 ovf=1", OutValid, Overflow);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    OutReady = 1'b0;
    fill(8'h31);
    OutReady = 1'b1;
    tick();
    checks++;
    if (Count !== 3'd3) begin errors++; $display("FAIL rmd_three got=%0d exp=3", Count); end
    #2;
    rst_n    = 1'b0;
    OutReady = 1'b0;
    ResValid = 1'b0;
    exp_q.delete();
    credits_m  = DEPTH;
    inflight_m = 0;
    ovf_m      = 1'b0;
    compliant  = 1'b1;
    #1;
    checks++;
    if (OutValid !== 1'b0 || Count !== 3'd0 || Credits !== 3'd4 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL rmd_async got v=%b c=%0d cr=%0d ovf=%b exp v=0 c=0 cr=4 ovf=0",
               OutValid, Count, Credits, Overflow);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    iss_data  = 32'hC0A0_0000;
    iss_flags = 5'h02;
    iss_tag   = 8'h5A;
    IssueReq  = 1'b1;
    tick();
    IssueReq = 1'b0;
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutTag !== 8'h5A || OutData !== 32'hC0A0_0000) begin
      errors++; $display("FAIL rmd_resume got v=%b tag=%h d=%h exp v=1 tag=5a d=c0a00000", OutValid, OutTag, OutData);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || Credits !== 3'd4) begin
      errors++; $display("FAIL rmd_final got v=%b cr=%0d exp v=0 cr=4", OutValid, Credits);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_push();
    test_random();
    test_full_push_pop();
    test_overflow();
    test_reset_mid_drain();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
